// File: rtl/seq_lock_pkg.sv
// ---------------------------------------------------------------------------
// seq_lock_pkg
// Shared definitions for the sequential code lock:
//   - lock_state_t : FSM state encoding (ENTRY, UNLOCKED, LOCKOUT)
//   - BCD_W        : width of the BCD progress digit
//   - CODE_MAX_W   : widest packed code the lock supports (9 digits x 4 bits)
//   - code_digit() : extracts one digit from a packed code word
// No ports; imported with "import seq_lock_pkg::*;".
// ---------------------------------------------------------------------------
package seq_lock_pkg;

    // Two bits cover the three legal states; the fourth encoding is illegal
    // and the lock FSM steers it back to ENTRY.
    typedef enum logic [1:0] {
        ENTRY    = 2'b00,
        UNLOCKED = 2'b01,
        LOCKOUT  = 2'b10
    } lock_state_t;

    localparam int BCD_W      = 4;
    localparam int CODE_MAX_W = 36;

    // Returns digit idx of a packed code whose digits are btn_w bits wide.
    // Digit 0 sits in the least significant bits and is entered first.
    function automatic logic [3:0] code_digit(input logic [CODE_MAX_W-1:0] code,
                                              input logic [3:0]            idx,
                                              input int                    btn_w);
        int         shamt;
        logic [3:0] mask;
        shamt = 32'(idx) * btn_w;
        mask  = (4'd1 << btn_w) - 4'd1;
        return 4'(code >> shamt) & mask;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// ---------------------------------------------------------------------------
// lock_timer
// Loadable down-counter shared by the lockout and auto-relock countdowns.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset (clears the count)
//   load     in   load load_val this cycle (wins over en)
//   load_val in   value to load
//   en       in   decrement by one while non-zero
//   zero     out  count is zero
// ---------------------------------------------------------------------------
module lock_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // The count parks at zero so the owner can sample zero for as long as
    // it needs without the counter wrapping underneath it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_code_lock.sv
// ---------------------------------------------------------------------------
// seq_code_lock
// N-digit button code lock with failed-attempt counting, timed lockout and
// simultaneous-press rejection.
// Ports:
//   clk         in   system clock, all logic on posedge
//   RST_BTN_N   in   synchronous active-low reset
//   btn         in   NUM_BTNS one-cycle press pulses (bit k = button k)
//   unlocked    out  high while the code has been matched
//   progress    out  BCD count of correct digits entered (0..CODE_LEN)
//   locked_out  out  high while presses are ignored after too many failures
//   fail_cnt    out  failed attempts since the last unlock or reset
// Optional feature: define SEQ_LOCK_AUTO_RELOCK_EN to re-lock automatically
// RELOCK_CYCLES cycles after unlocking when no button is pressed.
// ---------------------------------------------------------------------------
module seq_code_lock
    import seq_lock_pkg::*;
#(
    parameter int NUM_BTNS       = 2,
    parameter int CODE_LEN       = 5,
    parameter     CODE           = 5'b11010,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int RELOCK_CYCLES  = 32
) (
    input  logic               clk,
    input  logic               RST_BTN_N,
    input  logic [NUM_BTNS-1:0] btn,
    output logic               unlocked,
    output logic [BCD_W-1:0]   progress,
    output logic               locked_out,
    output logic [BCD_W-1:0]   fail_cnt
);

    localparam int BTN_W = (NUM_BTNS > 2) ? $clog2(NUM_BTNS) : 1;

    // One counter serves both countdowns, so it is sized for the longer one
    // in every build; that keeps the datapath identical with or without
    // auto-relock.
    localparam int TIMER_MAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
    localparam int TIMER_W   = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_W-1:0]    LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
`ifdef SEQ_LOCK_AUTO_RELOCK_EN
    localparam logic [TIMER_W-1:0]    RELOCK_LOAD  = TIMER_W'(RELOCK_CYCLES - 1);
`endif
    localparam logic [CODE_MAX_W-1:0] CODE_EXT     = CODE_MAX_W'(CODE);
    localparam logic [BCD_W-1:0]      FULL_P       = BCD_W'(CODE_LEN);
    localparam logic [BCD_W-1:0]      LAST_P       = BCD_W'(CODE_LEN - 1);
    localparam logic [BCD_W-1:0]      MAX_F        = BCD_W'(MAX_FAILS);

    lock_state_t        state;
    lock_state_t        next_state;
    logic [BCD_W-1:0]   next_progress;
    logic [BCD_W-1:0]   next_fail;
    logic [BCD_W-1:0]   fail_inc;
    logic [3:0]         press_k;
    logic [3:0]         digit_p;
    logic [3:0]         digit_0;
    logic               pressed;
    logic               single;
    logic               press_ok;
    logic [BCD_W-1:0]   restart_p;
    logic               timer_load;
    logic               timer_en;
    logic [TIMER_W-1:0] timer_val;
    logic               timer_zero;

    lock_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (RST_BTN_N),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    // Press decode: index of the pressed button; only meaningful when exactly
    // one bit is set, since simultaneous presses are always treated as wrong.
    always_comb begin
        press_k = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (btn[i]) begin
                press_k = 4'(i);
            end
        end
    end

    assign pressed   = |btn;
    assign single    = $onehot(btn);
    assign digit_p   = code_digit(CODE_EXT, progress, BTN_W);
    assign digit_0   = code_digit(CODE_EXT, 4'd0, BTN_W);
    assign press_ok  = single && (press_k == digit_p);
    assign restart_p = (single && (press_k == digit_0)) ? BCD_W'(1) : '0;
    assign fail_inc  = (fail_cnt == MAX_F) ? fail_cnt : fail_cnt + BCD_W'(1);

    // State, progress and failure count registers; reset overrides any
    // entry, lockout or unlock in progress.
    always_ff @(posedge clk) begin
        if (!RST_BTN_N) begin
            state    <= ENTRY;
            progress <= '0;
            fail_cnt <= '0;
        end else begin
            state    <= next_state;
            progress <= next_progress;
            fail_cnt <= next_fail;
        end
    end

    // Next-state logic. A wrong press with no digits yet entered is not an
    // attempt, so it never counts as a failure. A wrong press that happens to
    // match digit 0 starts the next attempt immediately.
    always_comb begin
        next_state    = state;
        next_progress = progress;
        next_fail     = fail_cnt;
        timer_load    = 1'b0;
        timer_en      = 1'b0;
        timer_val     = LOCKOUT_LOAD;
        case (state)
            ENTRY: begin
                if (pressed) begin
                    if (press_ok) begin
                        if (progress == LAST_P) begin
                            next_state    = UNLOCKED;
                            next_progress = FULL_P;
                            next_fail     = '0;
`ifdef SEQ_LOCK_AUTO_RELOCK_EN
                            timer_load    = 1'b1;
                            timer_val     = RELOCK_LOAD;
`endif
                        end else begin
                            next_progress = progress + BCD_W'(1);
                        end
                    end else if (progress != '0) begin
                        next_fail = fail_inc;
                        if (fail_inc == MAX_F) begin
                            next_state    = LOCKOUT;
                            next_progress = '0;
                            timer_load    = 1'b1;
                            timer_val     = LOCKOUT_LOAD;
                        end else begin
                            next_progress = restart_p;
                        end
                    end
                end
            end
            UNLOCKED: begin
`ifdef SEQ_LOCK_AUTO_RELOCK_EN
                timer_en = 1'b1;
`endif
                if (pressed) begin
                    next_state    = ENTRY;
                    next_progress = restart_p;
`ifdef SEQ_LOCK_AUTO_RELOCK_EN
                end else if (timer_zero) begin
                    next_state    = ENTRY;
                    next_progress = '0;
`endif
                end
            end
            LOCKOUT: begin
                timer_en      = 1'b1;
                next_progress = '0;
                if (timer_zero) begin
                    next_state = ENTRY;
                    next_fail  = '0;
                end
            end
            default: begin
                next_state    = ENTRY;
                next_progress = '0;
            end
        endcase
    end

    assign unlocked   = (state == UNLOCKED);
    assign locked_out = (state == LOCKOUT);

endmodule

// File: tb/tb_seq_code_lock.sv
// ---------------------------------------------------------------------------
// tb_seq_code_lock
// Self-checking bench for seq_code_lock at default parameters. A behavioural
// model tracks the lock from the press rules and predicts all outputs.
// Define SEQ_LOCK_AUTO_RELOCK_EN to also exercise the auto-relock timeout.
// ---------------------------------------------------------------------------
module tb_seq_code_lock;

    localparam int NUM_BTNS       = 2;
    localparam int CODE_LEN       = 5;
    localparam int MAX_FAILS      = 3;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int RELOCK_CYCLES  = 32;

    logic                clk       = 1'b0;
    logic                RST_BTN_N = 1'b0;
    logic [NUM_BTNS-1:0] btn       = '0;
    logic                unlocked;
    logic [3:0]          progress;
    logic                locked_out;
    logic [3:0]          fail_cnt;
    logic [9:0]          observed;

    int code_digits [5] = '{0, 1, 0, 1, 1};

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_unlocked;
    int m_progress;
    int m_fails;
    int m_lock_left;
`ifdef SEQ_LOCK_AUTO_RELOCK_EN
    int m_relock_left;
`endif

    seq_code_lock #(
        .NUM_BTNS       (NUM_BTNS),
        .CODE_LEN       (CODE_LEN),
        .CODE           (5'b11010),
        .MAX_FAILS      (MAX_FAILS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .RELOCK_CYCLES  (RELOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .RST_BTN_N  (RST_BTN_N),
        .btn        (btn),
        .unlocked   (unlocked),
        .progress   (progress),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    assign observed = {unlocked, locked_out, fail_cnt, progress};

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [9:0] expected_outputs();
        return {m_unlocked, (m_lock_left > 0), 4'(m_fails), 4'(m_progress)};
    endfunction

    function automatic logic [1:0] digit_btn(input int d);
        return (d == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic model_reset();
        m_unlocked  = 1'b0;
        m_progress  = 0;
        m_fails     = 0;
        m_lock_left = 0;
    endtask

    // One clock edge of the lock, from the rules: correct digits advance,
    // a wrong press after progress is a failure, MAX_FAILS failures lock out,
    // any press while open closes the lock again.
    task automatic model_step(input logic [1:0] b);
        bit single;
        int k;
        single = (b == 2'b01) || (b == 2'b10);
        k      = b[1] ? 1 : 0;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (m_unlocked) begin
            if (b != 2'b00) begin
                m_unlocked = 1'b0;
                m_progress = (single && k == code_digits[0]) ? 1 : 0;
            end
`ifdef SEQ_LOCK_AUTO_RELOCK_EN
            else begin
                m_relock_left--;
                if (m_relock_left == 0) begin
                    m_unlocked = 1'b0;
                    m_progress = 0;
                end
            end
`endif
        end else if (b != 2'b00) begin
            if (single && k == code_digits[m_progress]) begin
                m_progress++;
                if (m_progress == CODE_LEN) begin
                    m_unlocked = 1'b1;
                    m_fails    = 0;
`ifdef SEQ_LOCK_AUTO_RELOCK_EN
                    m_relock_left = RELOCK_CYCLES;
`endif
                end
            end else if (m_progress > 0) begin
                m_fails++;
                if (m_fails == MAX_FAILS) begin
                    m_lock_left = LOCKOUT_CYCLES;
                    m_progress  = 0;
                end else begin
                    m_progress = (single && k == code_digits[0]) ? 1 : 0;
                end
            end
        end
    endtask

    task automatic press(input logic [1:0] b);
        @(negedge clk);
        btn = b;
        @(posedge clk);
        model_step(b);
        #1;
        btn = '0;
    endtask

    task automatic apply_reset(input logic [1:0] b);
        @(negedge clk);
        RST_BTN_N = 1'b0;
        btn       = b;
        @(posedge clk);
        model_reset();
        #1;
        RST_BTN_N = 1'b1;
        btn       = '0;
    endtask

    task automatic test_reset();
        apply_reset(2'b11);
        checks++;
        if (observed !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: got %b, expected %b", observed, 10'b0);
        end
        press(2'b00);
        checks++;
        if (observed !== expected_outputs()) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %b, expected %b", observed, expected_outputs());
        end
    endtask

    task automatic test_unlock_sequence();
        apply_reset(2'b00);
        for (int i = 0; i < CODE_LEN; i++) begin
            press(digit_btn(code_digits[i]));
            checks++;
            if (observed !== expected_outputs()) begin
                errors++;
                $display("[TB] FAIL unlock_seq step %0d: got %b, expected %b", i, observed, expected_outputs());
            end
        end
        checks++;
        if ({unlocked, progress, fail_cnt} !== {1'b1, 4'd5, 4'd0}) begin
            errors++;
            $display("[TB] FAIL unlock_final: got u=%b p=%0d f=%0d, expected u=1 p=5 f=0", unlocked, progress, fail_cnt);
        end
    endtask

    task automatic test_multi_press();
        logic [1:0] seq [3] = '{2'b01, 2'b10, 2'b11};
        apply_reset(2'b00);
        for (int i = 0; i < 3; i++) begin
            press(seq[i]);
            checks++;
            if (observed !== expected_outputs()) begin
                errors++;
                $display("[TB] FAIL multi_press step %0d: got %b, expected %b", i, observed, expected_outputs());
            end
        end
        checks++;
        if ({fail_cnt, progress} !== {4'd1, 4'd0}) begin
            errors++;
            $display("[TB] FAIL multi_press_fail: got f=%0d p=%0d, expected f=1 p=0", fail_cnt, progress);
        end
        for (int i = 0; i < CODE_LEN; i++) begin
            press(digit_btn(code_digits[i]));
            checks++;
            if (observed !== expected_outputs()) begin
                errors++;
                $display("[TB] FAIL multi_press_code step %0d: got %b, expected %b", i, observed, expected_outputs());
            end
        end
        checks++;
        if ({unlocked, fail_cnt} !== {1'b1, 4'd0}) begin
            errors++;
            $display("[TB] FAIL multi_press_unlock: got u=%b f=%0d, expected u=1 f=0", unlocked, fail_cnt);
        end
    endtask

    task automatic test_lockout();
        int lock_cycles;
        apply_reset(2'b00);
        press(2'b01);
        for (int i = 0; i < MAX_FAILS; i++) begin
            press(2'b01);
            checks++;
            if (observed !== expected_outputs()) begin
                errors++;
                $display("[TB] FAIL lockout_entry step %0d: got %b, expected %b", i, observed, expected_outputs());
            end
        end
        checks++;
        if (locked_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lockout_asserted: got %b, expected 1", locked_out);
        end
        lock_cycles = 1;
        for (int i = 0; i < 40; i++) begin
            press(2'($urandom_range(0, 3)));
            checks++;
            if (observed !== expected_outputs()) begin
                errors++;
                $display("[TB] FAIL lockout_hold cycle %0d: got %b, expected %b", i, observed, expected_outputs());
            end
            if (locked_out) lock_cycles++;
            else break;
        end
        checks++;
        if (lock_cycles !== LOCKOUT_CYCLES) begin
            errors++;
            $display("[TB] FAIL lockout_duration: got %0d cycles, expected %0d", lock_cycles, LOCKOUT_CYCLES);
        end
        for (int i = 0; i < CODE_LEN; i++) begin
            press(digit_btn(code_digits[i]));
        end
        checks++;
        if ({unlocked, locked_out, fail_cnt} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL lockout_recover: got u=%b lo=%b f=%0d, expected u=1 lo=0 f=0", unlocked, locked_out, fail_cnt);
        end
    endtask

    task automatic test_relock();
        apply_reset(2'b00);
        for (int i = 0; i < CODE_LEN; i++) press(digit_btn(code_digits[i]));
        press(2'b01);
        checks++;
        if ({unlocked, progress} !== {1'b0, 4'd1}) begin
            errors++;
            $display("[TB] FAIL relock_press: got u=%b p=%0d, expected u=0 p=1", unlocked, progress);
        end
        for (int i = 1; i < CODE_LEN; i++) begin
            press(digit_btn(code_digits[i]));
            checks++;
            if (observed !== expected_outputs()) begin
                errors++;
                $display("[TB] FAIL relock_code step %0d: got %b, expected %b", i, observed, expected_outputs());
            end
        end
        checks++;
        if ({unlocked, fail_cnt} !== {1'b1, 4'd0}) begin
            errors++;
            $display("[TB] FAIL relock_unlock: got u=%b f=%0d, expected u=1 f=0", unlocked, fail_cnt);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(2'b00);
        press(2'b01);
        press(2'b10);
        press(2'b01);
        apply_reset(2'b10);
        checks++;
        if (observed !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_entry: got %b, expected %b", observed, 10'b0);
        end
        for (int i = 0; i < 4; i++) press(2'b01);
        press(2'b00);
        press(2'b11);
        apply_reset(2'b01);
        checks++;
        if (observed !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_lockout: got %b, expected %b", observed, 10'b0);
        end
        press(2'b00);
        checks++;
        if (observed !== expected_outputs()) begin
            errors++;
            $display("[TB] FAIL reset_mid_after: got %b, expected %b", observed, expected_outputs());
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                apply_reset(2'($urandom_range(0, 3)));
            end else if (r < 50 && !m_unlocked && m_lock_left == 0) begin
                press(digit_btn(code_digits[m_progress]));
            end else if (r < 70) begin
                press(2'b00);
            end else begin
                press(2'($urandom_range(0, 3)));
            end
            checks++;
            if (observed !== expected_outputs()) begin
                errors++;
                $display("[TB] FAIL random iter %0d: got %b, expected %b", i, observed, expected_outputs());
            end
        end
    endtask

`ifdef SEQ_LOCK_AUTO_RELOCK_EN
    task automatic test_auto_relock();
        int open_cycles;
        apply_reset(2'b00);
        for (int i = 0; i < CODE_LEN; i++) press(digit_btn(code_digits[i]));
        open_cycles = 1;
        for (int i = 0; i < 50; i++) begin
            press(2'b00);
            checks++;
            if (observed !== expected_outputs()) begin
                errors++;
                $display("[TB] FAIL auto_relock cycle %0d: got %b, expected %b", i, observed, expected_outputs());
            end
            if (unlocked) open_cycles++;
            else break;
        end
        checks++;
        if (open_cycles !== RELOCK_CYCLES || progress !== 4'd0) begin
            errors++;
            $display("[TB] FAIL auto_relock_duration: got %0d cycles p=%0d, expected %0d cycles p=0", open_cycles, progress, RELOCK_CYCLES);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_unlock_sequence();
        test_multi_press();
        test_lockout();
        test_relock();
        test_reset_mid();
`ifdef SEQ_LOCK_AUTO_RELOCK_EN
        test_auto_relock();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
